// File: rtl/spec_add_recover.sv
// Carry-speculative block adder: each block guesses its carry-in from the top bits of the
// block below, then correction passes repair wrong guesses until the carries agree.
module spec_add_recover #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4,
  parameter int CNT_W = 16,
  localparam int NB   = WIDTH / BLK,
  localparam int FW   = $clog2(NB) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             spec_err,
  output logic [FW-1:0]    fix_cnt,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [NB-1:0]    r_spec;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic [FW-1:0]    r_fix_cnt;
  logic [CNT_W-1:0] r_op_cnt;
  logic [CNT_W-1:0] r_err_cnt;

  logic [NB-1:0]    w_spec_init;
  logic [WIDTH-1:0] w_sum;
  logic [NB-1:0]    w_co;
  logic [NB-1:0]    w_err;
  logic             w_mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Initial guess: a block carries in when both top bits of the block below are set.
  always_comb begin
    w_spec_init    = '0;
    w_spec_init[0] = cin;
    for (int k = 1; k < NB; k++) begin
      w_spec_init[k] = a[k*BLK-1] & b[k*BLK-1];
    end
  end

  always_comb begin
    w_sum = '0;
    w_co  = '0;
    w_err = '0;
    for (int k = 0; k < NB; k++) begin
      {w_co[k], w_sum[k*BLK +: BLK]} = {1'b0, r_a[k*BLK +: BLK]} + {1'b0, r_b[k*BLK +: BLK]}
                                       + {{BLK{1'b0}}, r_spec[k]};
    end
    for (int k = 1; k < NB; k++) begin
      w_err[k] = w_co[k-1] ^ r_spec[k];
    end
  end

  assign w_mismatch = |w_err;

  // Operand and guess registers; a wrong guess flips to the real carry from below.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && in_valid) begin
      r_a    <= a;
      r_b    <= b;
      r_spec <= w_spec_init;
    end else if (r_state == S_EVAL) begin
      r_spec <= r_spec ^ w_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_fix_cnt <= '0;
      r_op_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_fix_cnt <= '0;
            r_state   <= S_EVAL;
          end
        end
        S_EVAL: begin
          r_sum <= w_sum;
          if (w_mismatch) begin
            r_fix_cnt <= r_fix_cnt + FW'(1);
          end else begin
            r_cout  <= w_co[NB-1];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state  <= S_IDLE;
            r_op_cnt <= sat_inc(r_op_cnt);
            if (r_fix_cnt != '0) r_err_cnt <= sat_inc(r_err_cnt);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign fix_cnt   = r_fix_cnt;
  assign spec_err  = (r_fix_cnt != '0);
  assign op_cnt    = r_op_cnt;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_spec_add_recover.sv
// Bench for spec_add_recover: directed and random additions against a carry-guess model.
module tb_spec_add_recover;
  localparam int WIDTH = 16;
  localparam int BLK   = 4;
  localparam int NB    = WIDTH / BLK;
  localparam int CNT_W = 4;
  localparam int FW    = $clog2(NB) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             spec_err;
  logic [FW-1:0]    fix_cnt;
  logic [CNT_W-1:0] op_cnt;
  logic [CNT_W-1:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int exp_op = 0;
  int exp_err = 0;

  spec_add_recover #(.WIDTH(WIDTH), .BLK(BLK), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .spec_err(spec_err),
    .fix_cnt(fix_cnt), .op_cnt(op_cnt), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Passes needed: keep replacing each guessed block carry-in with the carry the block
  // below actually produces under its current guess, until nothing changes.
  function automatic int model_fix(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                                   input logic tc);
    int  blk_sum [NB];
    bit  guess [NB];
    bit  co [NB];
    bit  changed;
    int  passes = 0;
    for (int k = 0; k < NB; k++) begin
      blk_sum[k] = int'((ta >> (k*BLK)) & ((1 << BLK) - 1)) + int'((tb >> (k*BLK)) & ((1 << BLK) - 1));
      guess[k]   = (k == 0) ? tc : (ta[k*BLK-1] & tb[k*BLK-1]);
    end
    for (int it = 0; it < 16; it++) begin
      changed = 1'b0;
      for (int k = 0; k < NB; k++) co[k] = ((blk_sum[k] + int'(guess[k])) >> BLK) & 1;
      for (int k = 1; k < NB; k++) if (co[k-1] != guess[k]) changed = 1'b1;
      if (!changed) break;
      for (int k = 1; k < NB; k++) guess[k] = co[k-1];
      passes++;
    end
    return passes;
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic tc,
                        input int hold);
    logic [WIDTH:0] full;
    int ef;
    int lat;
    full = {1'b0, ta} + {1'b0, tb} + {{WIDTH{1'b0}}, tc};
    ef   = model_fix(ta, tb, tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("latency", 32'(lat), 32'(2 + ef));
    chk("fix_le_max", 32'(int'(fix_cnt) <= NB - 1), 32'd1);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin @(posedge clk); @(negedge clk); end
      chk("sum", 32'(sum), 32'(full[WIDTH-1:0]));
      chk("cout", 32'(cout), 32'(full[WIDTH]));
      chk("fix_cnt", 32'(fix_cnt), 32'(ef));
      chk("spec_err", 32'(spec_err), 32'(ef != 0));
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      chk("op_cnt_hold", 32'(op_cnt), 32'(exp_op));
      chk("err_cnt_hold", 32'(err_cnt), 32'(exp_err));
      if (h > 0) chk("out_valid_hold", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    if (exp_op < CMAX) exp_op++;
    if (ef != 0 && exp_err < CMAX) exp_err++;
    chk("back_idle", 32'(in_ready), 32'd1);
    chk("out_valid_clr", 32'(out_valid), 32'd0);
    chk("op_cnt", 32'(op_cnt), 32'(exp_op));
    chk("err_cnt", 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_spec_err", 32'(spec_err), 32'd0);
    chk("rst_fix", 32'(fix_cnt), 32'd0);
    chk("rst_op", 32'(op_cnt), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst = 1'b0;

    run_op(16'h0001, 16'h0002, 1'b0, 0);
    run_op(16'h0008, 16'h0008, 1'b0, 0);
    run_op(16'h000F, 16'h0001, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h0FFF, 16'h0001, 1'b0, 4);
    run_op(16'hFFFF, 16'h0000, 1'b1, 1);

    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 2))
        0: rb = WIDTH'($urandom);
        1: rb = ~ra;
        default: rb = ~ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
      endcase
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 2));
    end

    // Reset during the second evaluation cycle of the worst-case ripple.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_op = 0; exp_err = 0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_op", 32'(op_cnt), 32'd0);
    chk("mid_rst_err", 32'(err_cnt), 32'd0);
    chk("mid_rst_fix", 32'(fix_cnt), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); @(negedge clk);
      chk("no_emit_after_rst", 32'(out_valid), 32'd0);
    end
    run_op(16'h0001, 16'h0002, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
